// File: rtl/pb_port_arbiter.sv
// Round-robin arbiter sharing the single port of the 512x16 program/display RAM
// between requester 0 (game/control) and requester 1 (memory debug engine).
// Registers address/write data/write enable toward the RAM and returns read data
// two cycles after each accepted read beat, tagged to the requester that issued it.
// Optional feature: define PB_ARB_BURST_LIMIT_EN to revoke a grant after MAX_BURST
// beats when the other requester is waiting.
module pb_port_arbiter #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic              wren0_i,
  output logic              gnt0_o,
  output logic              rvalid0_o,
  input  logic              req1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  input  logic              wren1_i,
  output logic              gnt1_o,
  output logic              rvalid1_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_wren_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  localparam logic [1:0] ArbIdle = 2'd0;
  localparam logic [1:0] ArbGnt0 = 2'd1;
  localparam logic [1:0] ArbGnt1 = 2'd2;

`ifdef PB_ARB_BURST_LIMIT_EN
  localparam bit LimitEn = 1'b1;
`else
  localparam bit LimitEn = 1'b0;
`endif

  logic [1:0]        state_q, state_d;
  logic              last_q, last_d;      // requester served most recently
  logic [ADDR_W:0]   cnt_q, cnt_d;        // beats taken under the current grant
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_wren_q;
  logic              rd_v1_q, rd_tag1_q;  // read pipeline stage 1: valid, owner
  logic              rd_v2_q, rd_tag2_q;  // read pipeline stage 2: valid, owner
  logic [DATA_W-1:0] rdata_q;
  logic              beat0, beat1, beat, beat_wr, limit_hit;

  assign beat0   = req0_i & (state_q == ArbGnt0);
  assign beat1   = req1_i & (state_q == ArbGnt1);
  assign beat    = beat0 | beat1;
  assign beat_wr = beat0 ? wren0_i : (beat1 & wren1_i);

  // Limit fires on the beat that brings the count to MAX_BURST, so no extra beat slips in.
  assign limit_hit = LimitEn && beat && ((int'(cnt_q) + 1) >= MAX_BURST);

  // Grant state machine with round-robin tie-break on the last-served pointer.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ArbIdle: begin
        if (req0_i && (!req1_i || last_q)) state_d = ArbGnt0;
        else if (req1_i)                   state_d = ArbGnt1;
      end
      ArbGnt0: begin
        if (!req0_i || (limit_hit && req1_i)) begin
          last_d  = 1'b0;
          state_d = req1_i ? ArbGnt1 : ArbIdle;
        end
      end
      ArbGnt1: begin
        if (!req1_i || (limit_hit && req0_i)) begin
          last_d  = 1'b1;
          state_d = req0_i ? ArbGnt0 : ArbIdle;
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  // Beat counter: cleared on any grant change, saturating at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)        cnt_d = '0;
    else if (beat && cnt_q != '1)  cnt_d = cnt_q + 1'b1;
  end

  // Arbiter state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ArbIdle;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // RAM command registers and the two-stage read return pipeline.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wren_q  <= 1'b0;
      rd_v1_q     <= 1'b0;
      rd_tag1_q   <= 1'b0;
      rd_v2_q     <= 1'b0;
      rd_tag2_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      mem_wren_q <= beat & beat_wr;
      if (beat) begin
        mem_addr_q  <= beat0 ? addr0_i : addr1_i;
        mem_wdata_q <= beat0 ? wdata0_i : wdata1_i;
      end
      rd_v1_q   <= beat & ~beat_wr;
      rd_tag1_q <= beat1;
      rd_v2_q   <= rd_v1_q;
      rd_tag2_q <= rd_tag1_q;
      rdata_q   <= rdata_o;
    end
  end

  // RAM data arrives one cycle after the address, so pass it straight through.
  always_comb begin
    rdata_o   = rd_v2_q ? mem_rdata_i : rdata_q;
    rvalid0_o = rd_v2_q & ~rd_tag2_q;
    rvalid1_o = rd_v2_q & rd_tag2_q;
  end

  assign gnt0_o      = (state_q == ArbGnt0);
  assign gnt1_o      = (state_q == ArbGnt1);
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wren_o  = mem_wren_q;
  assign busy_o      = (state_q != ArbIdle) | rd_v1_q | rd_v2_q;

endmodule

// File: tb/tb_pb_port_arbiter.sv
// Scoreboard bench for pb_port_arbiter: a transaction-level model predicts grants,
// RAM commands and read returns; a negedge monitor pops and compares them.
module tb_pb_port_arbiter;

  localparam int MaxB = 4;
`ifdef PB_ARB_BURST_LIMIT_EN
  localparam bit Lim = 1'b1;
`else
  localparam bit Lim = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic req0, wren0, gnt0, rvalid0, req1, wren1, gnt1, rvalid1;
  logic [8:0]  addr0, addr1, mem_addr;
  logic [15:0] wdata0, wdata1, rdata, mem_wdata, mem_rdata;
  logic mem_wren, busy;

  always #5 clk = ~clk;

  pb_port_arbiter #(.ADDR_W(9), .DATA_W(16), .MAX_BURST(MaxB)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .addr0_i(addr0), .wdata0_i(wdata0), .wren0_i(wren0),
    .gnt0_o(gnt0), .rvalid0_o(rvalid0),
    .req1_i(req1), .addr1_i(addr1), .wdata1_i(wdata1), .wren1_i(wren1),
    .gnt1_o(gnt1), .rvalid1_o(rvalid1),
    .rdata_o(rdata), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_wren_o(mem_wren), .mem_rdata_i(mem_rdata), .busy_o(busy)
  );

  // Synchronous RAM with one cycle read latency.
  logic [15:0] ram [512];
  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct { int due; logic [8:0] addr; logic [15:0] data; logic wr; } beat_t;
  typedef struct { int due; int owner; logic [15:0] data; } rd_t;
  typedef struct { int cyc; logic g0; logic g1; logic busy; } obs_t;

  beat_t bq[$];
  rd_t   rq[$];
  obs_t  oq[$];

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  // Reference model state: who owns the port, who was served last, reads in flight.
  int m_owner = 2;  // 2 = nobody
  int m_last = 1;
  int m_beats = 0;
  int m_last_rd = -100;
  logic [15:0] ref_mem [512];
  logic [15:0] rd_hold = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s cyc=%0d actual=missing required=present", name, cyc);
  endtask

  // One clock cycle of stimulus plus the model's view of that cycle.
  task automatic step(input logic r0, input logic [8:0] a0, input logic [15:0] d0,
                      input logic w0, input logic r1, input logic [8:0] a1,
                      input logic [15:0] d1, input logic w1, input logic rs,
                      output logic b0, output logic b1);
    int nxt;
    logic rx, ro, bt, lim;
    beat_t be;
    rd_t rd;
    obs_t ob;
    @(posedge clk);
    #1;
    cyc++;
    req0 = r0; addr0 = a0; wdata0 = d0; wren0 = w0;
    req1 = r1; addr1 = a1; wdata1 = d1; wren1 = w1;
    rst = rs;
    ob.cyc  = cyc;
    ob.g0   = (m_owner == 0);
    ob.g1   = (m_owner == 1);
    ob.busy = (m_owner != 2) || (cyc - m_last_rd == 1) || (cyc - m_last_rd == 2);
    oq.push_back(ob);
    mon_en = 1'b1;
    b0 = 1'b0;
    b1 = 1'b0;
    if (rs) begin
      m_owner = 2; m_last = 1; m_beats = 0; m_last_rd = -100;
      while (rq.size() > 0 && rq[$].due > cyc) void'(rq.pop_back());
      while (bq.size() > 0 && bq[$].due > cyc) void'(bq.pop_back());
    end else begin
      b0 = (m_owner == 0) && r0;
      b1 = (m_owner == 1) && r1;
      bt = b0 || b1;
      if (bt) begin
        be.due  = cyc + 1;
        be.addr = b0 ? a0 : a1;
        be.data = b0 ? d0 : d1;
        be.wr   = b0 ? w0 : w1;
        bq.push_back(be);
        if (be.wr) ref_mem[be.addr] = be.data;
        else begin
          rd.due = cyc + 2; rd.owner = m_owner; rd.data = ref_mem[be.addr];
          rq.push_back(rd);
          m_last_rd = cyc;
        end
        m_beats++;
      end
      if (m_owner == 2) begin
        if (r0 && (!r1 || m_last == 1)) nxt = 0;
        else if (r1) nxt = 1;
        else nxt = 2;
      end else begin
        rx  = (m_owner == 0) ? r0 : r1;
        ro  = (m_owner == 0) ? r1 : r0;
        lim = Lim && bt && (m_beats >= MaxB) && ro;
        if (!rx || lim) begin
          m_last = m_owner;
          nxt = ro ? 1 - m_owner : 2;
        end else nxt = m_owner;
      end
      if (nxt != m_owner) m_beats = 0;
      m_owner = nxt;
    end
  endtask

  task automatic idle(input int n);
    logic b0, b1;
    for (int i = 0; i < n; i++)
      step(1'b0, 9'h0, 16'h0, 1'b0, 1'b0, 9'h0, 16'h0, 1'b0, 1'b0, b0, b1);
  endtask

  // Hold requester x until n beats are accepted, address/data advancing per beat.
  task automatic burst(input int x, input int n, input logic [8:0] a, input logic wr,
                       input logic [15:0] d, input logic other);
    int beats = 0;
    int guard = 0;
    logic b0, b1;
    while (beats < n && guard < 64) begin
      if (x == 0)
        step(1'b1, a + 9'(beats), d + 16'(beats), wr, other, 9'h0, 16'h0, 1'b0, 1'b0, b0, b1);
      else
        step(other, 9'h0, 16'h0, 1'b0, 1'b1, a + 9'(beats), d + 16'(beats), wr, 1'b0, b0, b1);
      if ((x == 0 && b0) || (x == 1 && b1)) beats++;
      guard++;
    end
    if (beats < n) fail("burst_timeout");
  endtask

  // Monitor: compares every cycle's outputs against the queued expectations.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (oq.size() > 0 && oq[0].cyc == cyc) begin
          chk("gnt0", gnt0, oq[0].g0);
          chk("gnt1", gnt1, oq[0].g1);
          chk("busy", busy, oq[0].busy);
          void'(oq.pop_front());
        end else fail("obs_slot");
        if (bq.size() > 0 && bq[0].due == cyc) begin
          chk("mem_wren", mem_wren, bq[0].wr);
          chk("mem_addr", mem_addr, bq[0].addr);
          if (bq[0].wr) chk("mem_wdata", mem_wdata, bq[0].data);
          void'(bq.pop_front());
        end else chk("mem_wren_idle", mem_wren, 1'b0);
        if (rq.size() > 0 && rq[0].due == cyc) begin
          chk("rvalid0", rvalid0, rq[0].owner == 0);
          chk("rvalid1", rvalid1, rq[0].owner == 1);
          chk("rdata", rdata, rq[0].data);
          rd_hold = rq[0].data;
          void'(rq.pop_front());
        end else begin
          chk("rvalid_idle", {rvalid1, rvalid0}, 2'b00);
          chk("rdata_hold", rdata, rd_hold);
        end
        if (rst) rd_hold = 16'h0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic b0, b1;
    logic r0, r1;
    for (int i = 0; i < 512; i++) begin
      ram[i] = 16'h0;
      ref_mem[i] = 16'h0;
    end
    rst = 1'b1;
    req0 = 1'b0; addr0 = '0; wdata0 = '0; wren0 = 1'b0;
    req1 = 1'b0; addr1 = '0; wdata1 = '0; wren1 = 1'b0;
    repeat (3) @(posedge clk);

    // Reset state, then simultaneous requests resolve to requester 0.
    step(1'b0, 9'h0, 16'h0, 1'b0, 1'b0, 9'h0, 16'h0, 1'b0, 1'b1, b0, b1);
    chk("rst_mem_addr", mem_addr, 9'h0);
    chk("rst_rdata", rdata, 16'h0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 9'h0, 16'h0, 1'b0, 1'b1, 9'h0, 16'h0, 1'b0, 1'b0, b0, b1);
    for (int i = 0; i < 3; i++)
      step(1'b0, 9'h0, 16'h0, 1'b0, 1'b1, 9'h1, 16'h0, 1'b0, 1'b0, b0, b1);

    // Requester 0 write burst, then requester 1 reads it back with req0 pending.
    burst(0, 4, 9'h010, 1'b1, 16'h0001, 1'b0);
    step(1'b0, 9'h0, 16'h0, 1'b0, 1'b1, 9'h010, 16'h0, 1'b0, 1'b0, b0, b1);
    burst(1, 4, 9'h010, 1'b0, 16'h0000, 1'b1);
    step(1'b1, 9'h0, 16'h0, 1'b0, 1'b0, 9'h0, 16'h0, 1'b0, 1'b0, b0, b1);

    // Reset in the middle of a requester 0 write burst.
    burst(0, 2, 9'h040, 1'b1, 16'h0100, 1'b0);
    step(1'b1, 9'h042, 16'h0102, 1'b1, 1'b0, 9'h0, 16'h0, 1'b0, 1'b1, b0, b1);
    idle(3);

    // Long burst against a waiting requester 1.
    burst(0, 10, 9'h080, 1'b1, 16'h0200, 1'b1);
    step(1'b0, 9'h0, 16'h0, 1'b0, 1'b1, 9'h080, 16'h0, 1'b0, 1'b0, b0, b1);
    burst(1, 10, 9'h080, 1'b0, 16'h0000, 1'b0);
    idle(3);

    // Random traffic over a small address window so reads hit earlier writes.
    r0 = 1'b0;
    r1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) r0 = ~r0;
      if ($urandom_range(3) == 0) r1 = ~r1;
      step(r0, 9'($urandom_range(16, 31)), 16'($urandom), 1'($urandom),
           r1, 9'($urandom_range(16, 31)), 16'($urandom), 1'($urandom),
           ($urandom_range(99) == 0), b0, b1);
    end
    idle(5);

    chk("beats_drained", bq.size(), 0);
    chk("reads_drained", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pb_port_arbiter.md
Name: pb_port_arbiter

Overview:
Shares the single port of the 512x16 program/display block RAM between two requesters: requester 0 (game/control logic) and requester 1 (memory debug read/write engine).
- Grants one owner at a time, with round-robin fairness.
- Drives registered address, write data and write enable to the RAM.
- Returns synchronous read data to the owner with a fixed latency.
- Sits between both requesters and the RAM port mux.

Parameters:
ADDR_W, 9, RAM address width
DATA_W, 16, RAM data width
MAX_BURST, 16, beats one owner may take while the other waits (used only with PB_ARB_BURST_LIMIT_EN)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
req0  in  1  requester 0 wants the port; held for the whole burst
addr0  in  ADDR_W  requester 0 address
wdata0  in  DATA_W  requester 0 write data
wren0  in  1  requester 0 write (1) / read (0)
gnt0  out  1  requester 0 owns the port
rvalid0  out  1  rdata valid for requester 0
req1, addr1, wdata1, wren1, gnt1, rvalid1  same meanings, requester 1
rdata  out  DATA_W  read data, shared by both requesters
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_wren  out  1  RAM write enable
mem_rdata  in  DATA_W  RAM read data, 1 cycle after mem_addr
busy  out  1  a grant is held or a read is in flight

Behaviour:
- Reset: state ARB_IDLE; last-served pointer = 1; all outputs 0; read pipeline cleared. Reset mid-burst drops gnt and mem_wren in the next cycle; in-flight rvalid is suppressed.
- States:
  - ARB_IDLE → ARB_GNT0 if req0 and (!req1 or last=1).
  - ARB_IDLE → ARB_GNT1 if req1 and (!req0 or last=0).
  - ARB_GNTx holds while reqx=1.
  - On reqx=0: go directly to the other grant state if the other req=1, else ARB_IDLE. Set last=x.
- gnt0/gnt1 are registered decodes of state; they are never both 1.
- Beat: a cycle with reqx=1 and gntx=1. At most one beat per cycle; no beat is accepted in ARB_IDLE.
- Beat at cycle N:
  - N+1: mem_addr=addrx, mem_wdata=wdatax, mem_wren=wrenx.
  - Read beat: rdata=mem_rdata and rvalidx=1 at N+2.
- Non-beat cycles: mem_wren=0; mem_addr and mem_wdata hold their last value.
- Read pipeline: 2-stage valid+owner tag. rvalid goes to the requester that issued the beat, even if the grant has since moved. Back-to-back reads give one rvalid per cycle.
- Owner switch: at least one non-beat cycle, because req drops, then gnt moves on the next edge. No beat is lost or duplicated.
- rdata holds its last value when both rvalid are 0.
- busy = state != ARB_IDLE or any read valid in flight.
- Beat counter: ADDR_W+1 bits, counts beats of the current grant, cleared on every grant change, saturates at all-ones.

Optional Feature:
PB_ARB_BURST_LIMIT_EN
- Defined: when the beat counter reaches MAX_BURST and the other requester's req=1, the owner's grant is revoked. The arbiter passes to the other grant state on the next edge even though the owner's req is still 1. The former owner waits with req held and is re-granted under round-robin. If the other req=0, the limit has no effect.
- Undefined: the counter only feeds no logic and may be optimised away. The owner keeps the port until it drops req.

Test Plan:
- After reset: req0=req1=1 same cycle → gnt0=1 on cycle 2 (last=1), gnt1=0; drop req0 → gnt1=1 next edge.
- Req0 write burst, addr 0x010..0x013, wdata 0x0001..0x0004 → mem_wren=1 four cycles, mem_addr/wdata one cycle after each beat; RAM model holds the values.
- Req1 reads 0x010..0x013 back-to-back → rvalid1 on 4 consecutive cycles, rdata 0x0001..0x0004, first 2 cycles after the first beat; rvalid0 stays 0.
- Req1 issues its last read and drops req while req0 is pending → gnt0 rises; rvalid1 still fires for the in-flight read; no rvalid0.
- Assert rst during a req0 write burst → mem_wren=0, gnt0=0, busy=0 the next cycle; state ARB_IDLE.
- With PB_ARB_BURST_LIMIT_EN, MAX_BURST=4: req0 held 10 beats with req1=1 → gnt0 drops after beat 4, gnt1 granted; without the macro, gnt0 is held for all 10 beats.
